// File: rtl/param_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : param_ram_if
// Description : Request/ready access bus for param_ram. The master side drives
//               the access and clear requests. The slave side returns the
//               ready/busy status and the read response.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              clr;
    logic              inj_perr;
    logic              ready;
    logic              busy;
    logic              rvalid;
    logic [DATA_W-1:0] dout;
    logic              rd_perr;

    modport master (
        output req, we, addr, din, clr, inj_perr,
        input  ready, busy, rvalid, dout, rd_perr
    );

    modport slave (
        input  req, we, addr, din, clr, inj_perr,
        output ready, busy, rvalid, dout, rd_perr
    );
endinterface
`default_nettype wire

// File: rtl/param_ram.sv
`default_nettype none
// ============================================================================
// Module      : param_ram
// Description : Parametrised single-port synchronous RAM.
//               - Request/ready handshake.
//               - Read latency of 1 or 2 cycles.
//               - Hardware clear engine that zeroes the whole array after
//                 reset or on a clr request.
//               Optional per-word even parity is enabled by defining
//               PARAM_RAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module param_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    param_ram_if.slave  bus
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
`ifdef PARAM_RAM_PARITY_EN
    localparam int c_MEM_W = DATA_W + 1;
`else
    localparam int c_MEM_W = DATA_W;
`endif

    // Reject unsupported configurations at elaboration time.
    generate
        if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
            $error("param_ram: RD_LAT must be 1 or 2");
        end
        if ((DATA_W < 1) || (DATA_W > 64)) begin : g_bad_data_w
            $error("param_ram: DATA_W must be in 1..64");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;

    logic [c_MEM_W-1:0]  r_mem [c_DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [c_MEM_W-1:0]  w_mem_wdata;
    logic                w_rd_acc;
    logic [c_MEM_W-1:0]  w_wr_word;
    logic [c_MEM_W-1:0]  w_rd_word;
    logic                w_rd_perr;

    // Stage-1 read registers. They update only on an accepted read, so the
    // data holds the last read value between responses.
    logic                r_v1;
    logic [DATA_W-1:0]   r_d1;
    logic                r_p1;

    // Parity: the stored bit makes the whole word even. Any odd word read
    // back therefore signals a mismatch.
`ifdef PARAM_RAM_PARITY_EN
    assign w_wr_word = {(^bus.din) ^ bus.inj_perr, bus.din};
    assign w_rd_perr = ^w_rd_word;
`else
    logic w_unused_inj;
    assign w_unused_inj = bus.inj_perr;
    assign w_wr_word    = bus.din;
    assign w_rd_perr    = 1'b0;
`endif

    assign w_rd_word = r_mem[bus.addr];

    // The status outputs decode the state register only.
    // This keeps the input-to-output path free of logic.
    assign bus.ready = (r_state == S_IDLE);
    assign bus.busy  = (r_state == S_CLEAR);

    // FSM state and clear pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic and the array write-port / read-accept decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.addr;
        w_mem_wdata = w_wr_word;
        w_rd_acc    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                // One location per cycle. req and clr are ignored until
                // the sweep is complete.
                w_mem_we    = 1'b1;
                w_mem_addr  = r_ptr;
                w_mem_wdata = '0;
                w_ptr_nxt   = r_ptr + 1'b1;
                if (r_ptr == c_LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                // clr wins over a simultaneous access request.
                if (bus.clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end else if (bus.req) begin
                    if (bus.we) begin
                        w_mem_we = 1'b1;
                    end else begin
                        w_rd_acc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage array. It has no reset; the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // First read stage: sample the array on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_p1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_d1 <= w_rd_word[DATA_W-1:0];
                r_p1 <= w_rd_perr;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;
            logic              r_p2;

            // Output register stage that adds the second cycle of latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                    r_p2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                        r_p2 <= r_p1;
                    end
                end
            end

            assign bus.rvalid  = r_v2;
            assign bus.dout    = r_d2;
            assign bus.rd_perr = r_p2;
        end else begin : g_lat1
            assign bus.rvalid  = r_v1;
            assign bus.dout    = r_d1;
            assign bus.rd_perr = r_p1;
        end
    endgenerate

endmodule
`default_nettype wire
